adder: RTL and testbench

//  Registered unsigned adder: sums in1 + in2 and presents the WIDTH-bit result one clock later.

---
 rtl/add_pkg.sv | 13 +
 rtl/adder_comb.sv | 31 +++
 rtl/adder.sv | 73 +++++++
 tb/tb_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the registered adder: default width and the
// two's-complement overflow rule used by the combinational stage.
package add_pkg;

  localparam int ADD_WIDTH_DEF = 32;

  // Overflow occurs when both operands share a sign and the sum's sign differs.
  // Arguments are the sign bits of operand A, operand B and the unsaturated sum.
  function automatic logic add_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/adder_comb.sv
// Combinational core of the registered adder: produces the sum, carry-out and
// signed-overflow flag for one operand pair.
// Build option: define ADD_SATURATE_EN to clamp the sum to all-ones on carry-out;
// the flags are computed from the unsaturated sum in both builds.
module adder_comb
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] full;

  // Widen by one bit so the carry-out falls out of the addition directly.
  always_comb begin
    full     = {1'b0, in1} + {1'b0, in2};
    carry    = full[WIDTH];
    overflow = add_ovf(in1[WIDTH-1], in2[WIDTH-1], full[WIDTH-1]);
`ifdef ADD_SATURATE_EN
    sum      = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
    sum      = full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/adder.sv
// Registered unsigned adder with carry-out, signed-overflow and valid strobe.
// One cycle of latency, a new operand pair accepted every cycle.
// Build option: ADD_SATURATE_EN (handled inside adder_comb) saturates the sum.
// WIDTH is intended for the range 2..64.
module adder
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             overflow_c;

  logic [WIDTH-1:0] out_d,       out_q;
  logic             carry_d,     carry_q;
  logic             overflow_d,  overflow_q;
  logic             out_valid_d, out_valid_q;

  adder_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .in1      (in1),
    .in2      (in2),
    .sum      (sum_c),
    .carry    (carry_c),
    .overflow (overflow_c)
  );

  // Load a new result only when in_valid is high so undriven operands never reach the outputs.
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      out_d      = sum_c;
      carry_d    = carry_c;
      overflow_d = overflow_c;
    end
  end

  // Output registers; reset clears everything, discarding any result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the registered adder at WIDTH=32.
// Expected results come from a reference model using plain 64-bit integer
// arithmetic: unsigned range for carry, signed range for overflow.
module tb_adder;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic [W-1:0] out;
  logic         carry;
  logic         overflow;

  int vectors;
  int miscompares;

  adder #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out       (out),
    .carry     (carry),
    .overflow  (overflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: exact integer sum, then derive the wrapped/saturated result and flags.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c, output logic o);
    longint unsigned u;
    longint          sg;
    u  = longint'(a) + longint'(b);
    sg = longint'($signed(a)) + longint'($signed(b));
    c  = (u > 64'h0000_0000_FFFF_FFFF);
    o  = (sg > SMAX) || (sg < SMIN);
    s  = u[W-1:0];
`ifdef ADD_SATURATE_EN
    if (c) s = '1;
`endif
  endfunction

  // Present an operand pair on the falling edge, away from the sampling edge.
  task automatic drive_pair(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    in1      = a;
    in2      = b;
  endtask

  // Asynchronous reset must clear all outputs without waiting for a clock edge.
  task automatic test_reset();
    logic [W-1:0] es;
    logic         ec, eo;
    #3;
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_initial: got v=%b out=%h c=%b o=%b, want all zero",
               out_valid, out, carry, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_pair(1'b1, 32'h8000_0000, 32'h8000_0001);
    @(posedge clk); #1;
    ref_add(32'h8000_0000, 32'h8000_0001, es, ec, eo);
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b1, es, ec, eo}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_load: got v=%b out=%h c=%b o=%b, want v=1 out=%h c=%b o=%b",
               out_valid, out, carry, overflow, es, ec, eo);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got v=%b out=%h c=%b o=%b, want all zero",
               out_valid, out, carry, overflow);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Small operands never produce carry or overflow.
  task automatic test_random_small();
    logic [W-1:0] a, b, es;
    logic         ec, eo;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(31, 0));
      b = W'($urandom_range(31, 0));
      drive_pair(1'b1, a, b);
      @(posedge clk); #1;
      ref_add(a, b, es, ec, eo);
      vectors++;
      if ({out_valid, out, carry, overflow} !== {1'b1, es, ec, eo}) begin
        miscompares++;
        $display("[TB] FAIL small[%0d] %0d+%0d: got v=%b out=%h c=%b o=%b, want v=1 out=%h c=%b o=%b",
                 i, a, b, out_valid, out, carry, overflow, es, ec, eo);
      end
    end
  endtask

  // Full-width random pairs, one per cycle, with no idle gaps.
  task automatic test_back_to_back();
    logic [W-1:0] a, b, es;
    logic         ec, eo;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      drive_pair(1'b1, a, b);
      @(posedge clk); #1;
      ref_add(a, b, es, ec, eo);
      vectors++;
      if ({out_valid, out, carry, overflow} !== {1'b1, es, ec, eo}) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d] %h+%h: got v=%b out=%h c=%b o=%b, want v=1 out=%h c=%b o=%b",
                 i, a, b, out_valid, out, carry, overflow, es, ec, eo);
      end
    end
  endtask

  // Corner operands: zero, unsigned wrap, max+max, signed overflow both directions.
  task automatic test_boundaries();
    logic [W-1:0] av [6];
    logic [W-1:0] bv [6];
    logic [W-1:0] es;
    logic         ec, eo;
    av = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    bv = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      drive_pair(1'b1, av[i], bv[i]);
      @(posedge clk); #1;
      ref_add(av[i], bv[i], es, ec, eo);
      vectors++;
      if ({out_valid, out, carry, overflow} !== {1'b1, es, ec, eo}) begin
        miscompares++;
        $display("[TB] FAIL boundary[%0d] %h+%h: got v=%b out=%h c=%b o=%b, want v=1 out=%h c=%b o=%b",
                 i, av[i], bv[i], out_valid, out, carry, overflow, es, ec, eo);
      end
    end
  endtask

  // With in_valid low the result holds, even with unknown operands.
  task automatic test_hold();
    drive_pair(1'b1, 32'd3, 32'd4);
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b1, 32'd7, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL hold_load: got v=%b out=%h c=%b o=%b, want v=1 out=7 c=0 o=0",
               out_valid, out, carry, overflow);
    end
    drive_pair(1'b0, 32'd9, 'x);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, out, carry, overflow} !== {1'b0, 32'd7, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL hold[%0d]: got v=%b out=%h c=%b o=%b, want v=0 out=7 c=0 o=0",
                 i, out_valid, out, carry, overflow);
      end
    end
  endtask

  // Reset asserted before the capturing edge discards the pending pair.
  task automatic test_reset_mid_stream();
    drive_pair(1'b1, 32'd5, 32'd6);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got v=%b out=%h c=%b o=%b, want all zero",
               out_valid, out, carry, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in1   = 32'd7;
    in2   = 32'd8;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out, carry, overflow} !== {1'b1, 32'd15, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got v=%b out=%h c=%b o=%b, want v=1 out=f c=0 o=0",
               out_valid, out, carry, overflow);
    end
    drive_pair(1'b0, '0, '0);
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 32'd15) begin
      miscompares++;
      $display("[TB] FAIL after_reset_idle: got v=%b out=%h, want v=0 out=f", out_valid, out);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in1         = '0;
    in2         = '0;
    test_reset();
    test_random_small();
    test_back_to_back();
    test_boundaries();
    test_hold();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
